alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand width.
REQ-002 SHALL have parameter RESULT_WIDTH, default 32, result width.
REQ-003 SHALL have parameter CMD_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, cycles allowed in WAIT before timeout.
REQ-005 SHALL have ports as follows; reset rst, synchronous, active-high; clock clk:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 cmd_valid  in  1  command offered
 cmd_ready  out  1  command FIFO not full
 cmd_a  in  DATA_WIDTH  operand A
 cmd_b  in  DATA_WIDTH  operand B
 cmd_op  in  3  op_sel code
 alu_a  out  DATA_WIDTH  operand A to the ALU (A1)
 alu_b  out  DATA_WIDTH  operand B to the ALU (B1)
 alu_op  out  3  op_sel to the ALU
 alu_start  out  1  start_op pulse
 alu_end  in  1  end_op from the ALU
 alu_result  in  RESULT_WIDTH  ALU result
 rsp_valid  out  1  response available
 rsp_ready  in  1  response consumed
 rsp_result  out  RESULT_WIDTH  captured result
 rsp_op  out  3  op code of the response
 busy  out  1  FSM not in IDLE or FIFO not empty
 timeout_err  out  1  sticky timeout flag (present only with macro)

Function
REQ-006 SHALL push the command on cmd_valid && cmd_ready; cmd_ready = !full, derived from registered count only.
REQ-007 SHALL, with push and pop in the same cycle, leave count unchanged; pointers SHALL wrap modulo CMD_DEPTH.
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-009 IDLE: if FIFO not empty, pop the head into operand/op registers and go to ISSUE; else stay.
REQ-010 ISSUE: alu_start=1 for exactly one cycle; go to WAIT.
REQ-011 WAIT: on alu_end=1, capture alu_result into rsp_result and go to RESP; alu_end in any other state SHALL be ignored.
REQ-012 RESP: rsp_valid=1; on rsp_ready, go to IDLE; rsp_result/rsp_op SHALL hold stable while rsp_valid && !rsp_ready.
REQ-013 alu_a/alu_b/alu_op SHALL hold stable from ISSUE through capture in WAIT (the ALU multiplies live operands and muxes result on op_sel).
REQ-014 Latency: command accepted at edge N -> alu_start high in cycle N+2 at the earliest; one ALU operation outstanding at a time.
REQ-015 FIFO SHALL keep accepting commands while the FSM is in WAIT or RESP until full.

Reset
REQ-016 On rst: FIFO empty, FSM IDLE, alu_start=0, rsp_valid=0, rsp_result=0, rsp_op=0, alu_a/alu_b/alu_op=0, timeout_err=0; cmd_ready=1 in the first cycle after reset.
REQ-017 rst mid-operation SHALL discard the in-flight op and all queued commands; a late alu_end after reset SHALL be ignored (FSM in IDLE).

Configuration
REQ-018 Macro ALU_SEQ_TIMEOUT_EN defined: a WAIT counter SHALL increment; on reaching TIMEOUT_CYCLES without alu_end, go to RESP with rsp_result all ones and set timeout_err (sticky until rst).
REQ-019 Macro ALU_SEQ_TIMEOUT_EN undefined: no counter, no timeout_err port; WAIT is left only on alu_end.

Structure
REQ-020 Package alu_seq_pkg SHALL hold the FSM state enum, op_sel encoding constants (MUL=000, ADD=001, SUB=010, ADDC=011, OR=100, AND=101, XOR=110, NOT=111) and the command struct {a, b, op}.
REQ-021 Sub-module alu_cmd_fifo (synchronous FIFO, parameterised by width and depth) SHALL implement the command queue.

Verification
REQ-022 ADD: op=001, A=3, B=5 -> alu_end one cycle after alu_start; rsp_result=0x00000008.
REQ-023 MUL: op=000, A=0x0010, B=0x0020 -> alu_end three cycles after alu_start; rsp_result=0x00000200.
REQ-024 OR: op=100, A=0x00F0, B=0x000F -> alu_end one cycle after alu_start; rsp_result=0x000000FF.
REQ-025 Backpressure: rsp_ready=0, five commands offered back-to-back -> first command issued and held in RESP, remaining four fill the FIFO, cmd_ready low on the fifth; responses then return in order with no second alu_start until the first rsp handshake.
REQ-026 Timeout (macro defined): alu_end tied 0 -> rsp_valid after 16 WAIT cycles, rsp_result=0xFFFFFFFF, timeout_err=1.
REQ-027 Reset mid-MUL: rst asserted in WAIT with 2 commands queued -> all outputs return to reset values, alu_end arriving afterwards produces no rsp_valid.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM states, op_sel codes
// and the queued command layout. Timeout feature: ALU_SEQ_TIMEOUT_EN.
package alu_seq_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_MUL  = 3'b000;
  localparam op_t OP_ADD  = 3'b001;
  localparam op_t OP_SUB  = 3'b010;
  localparam op_t OP_ADDC = 3'b011;
  localparam op_t OP_OR   = 3'b100;
  localparam op_t OP_AND  = 3'b101;
  localparam op_t OP_XOR  = 3'b110;
  localparam op_t OP_NOT  = 3'b111;

  // Widest operand a queued command can carry.
  localparam int unsigned CMD_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } seq_state_e;

  typedef struct packed {
    logic [CMD_DW-1:0] a;
    logic [CMD_DW-1:0] b;
    op_t               op;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO holding pending ALU commands.
// Power-of-two depth, pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands and runs them one at a time through an external ALU.
// Define ALU_SEQ_TIMEOUT_EN to add the WAIT timeout and timeout_err.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned RESULT_WIDTH   = 32,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  input  logic [2:0]              cmd_op,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [2:0]              alu_op,
  output logic                    alu_start,
  input  logic                    alu_end,
  input  logic [RESULT_WIDTH-1:0] alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [RESULT_WIDTH-1:0] rsp_result,
  output logic [2:0]              rsp_op,
  output logic                    busy
`ifdef ALU_SEQ_TIMEOUT_EN
  ,
  output logic                    timeout_err
`endif
);

  seq_state_e              state_q, state_d;
  cmd_t                    head_q, head_d;
  logic                    alu_start_q, alu_start_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [RESULT_WIDTH-1:0] rsp_result_q, rsp_result_d;
  op_t                     rsp_op_q, rsp_op_d;

  cmd_t push_cmd, fifo_head;
  logic fifo_full, fifo_empty;
  logic push, pop;
  logic unused_hi;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_err_q, tmo_err_d;
  assign timeout_err = tmo_err_q;
`else
  localparam int unsigned unused_tmo_cycles = TIMEOUT_CYCLES;
`endif

  assign cmd_ready   = !fifo_full;
  assign push        = cmd_valid && cmd_ready;
  assign push_cmd.a  = CMD_DW'(cmd_a);
  assign push_cmd.b  = CMD_DW'(cmd_b);
  assign push_cmd.op = cmd_op;

  alu_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (push_cmd),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Operands stay in head_q from ISSUE until the next pop.
  assign alu_a      = head_q.a[DATA_WIDTH-1:0];
  assign alu_b      = head_q.b[DATA_WIDTH-1:0];
  assign alu_op     = head_q.op;
  assign alu_start  = alu_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_op     = rsp_op_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign unused_hi  = ^{head_q.a, head_q.b};

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    alu_start_d  = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    pop          = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
    tmo_d     = tmo_q;
    tmo_err_d = tmo_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          head_d      = fifo_head;
          alu_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      ST_WAIT: begin
        if (alu_end) begin
          rsp_result_d = alu_result;
          rsp_op_d     = head_q.op;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_result_d = '1;
          rsp_op_d     = head_q.op;
          rsp_valid_d  = 1'b1;
          tmo_err_d    = 1'b1;
          state_d      = ST_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      head_q       <= '0;
      alu_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      tmo_q        <= '0;
      tmo_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      alu_start_q  <= alu_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
`ifdef ALU_SEQ_TIMEOUT_EN
      tmo_q        <= tmo_d;
      tmo_err_q    <= tmo_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU.
// Timeout checks build only with ALU_SEQ_TIMEOUT_EN.
module tb_alu_cmd_sequencer;

  localparam int DW = 16;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a, cmd_b;
  logic [2:0]    cmd_op;
  logic [DW-1:0] alu_a, alu_b;
  logic [2:0]    alu_op;
  logic          alu_start;
  logic          alu_end;
  logic [RW-1:0] alu_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RW-1:0] rsp_result;
  logic [2:0]    rsp_op;
  logic          busy;
`ifdef ALU_SEQ_TIMEOUT_EN
  logic          timeout_err;
`endif

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DATA_WIDTH     (DW),
    .RESULT_WIDTH   (RW),
    .CMD_DEPTH      (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_end    (alu_end),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .busy       (busy)
`ifdef ALU_SEQ_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [RW-1:0] res;
    logic [2:0]    op;
  } exp_t;
  exp_t sb[$];

  // Behavioural ALU: result computed from live operands.
  int acnt    = 0;
  int lat_mul = 3;
  bit alu_en  = 1'b1;
  logic [RW-1:0] a32, b32;

  assign a32 = {16'h0, alu_a};
  assign b32 = {16'h0, alu_b};

  always @(posedge clk) begin
    if (alu_start) acnt <= (alu_op == 3'b000) ? lat_mul : 1;
    else if (acnt != 0) acnt <= acnt - 1;
  end

  assign alu_end = alu_en && (acnt == 1);

  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'b000: alu_result = a32 * b32;
      3'b001: alu_result = a32 + b32;
      3'b010: alu_result = a32 - b32;
      3'b011: alu_result = a32 + b32 + 32'd1;
      3'b100: alu_result = a32 | b32;
      3'b101: alu_result = a32 & b32;
      3'b110: alu_result = a32 ^ b32;
      default: alu_result = {16'h0, ~alu_a};
    endcase
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  int n_start = 0;
  int n_rsp   = 0;
  bit no_rsp  = 1'b0;

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (alu_start) n_start++;
      if (no_rsp && rsp_valid)
        chk("rsp_after_rst", rsp_valid, 0);
      if (rsp_valid && rsp_ready) begin
        chk("one_outstanding", n_start - n_rsp, 1);
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_op", rsp_op, e.op);
        end
        n_rsp++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a,
                      input logic [DW-1:0] b,
                      input logic [2:0] op,
                      input logic [RW-1:0] res);
    bit done;
    exp_t e;
    done = 1'b0;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    for (int i = 0; i < 200 && !done; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        e.res = res;
        e.op = op;
        sb.push_back(e);
        #1;
        done = 1'b1;
      end else begin
        tick();
      end
    end
    chk("send_accept", done, 1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (sb.size() == 0 && !busy && !rsp_valid) ok = 1'b1;
      else tick();
    end
    chk("drain", ok, 1);
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (alu_start) seen = 1'b1;
    end
    chk("start_seen", seen, 1);
  endtask

  task automatic reset_chk(input string tag);
    @(negedge clk);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_op"}, rsp_op, 0);
    chk({tag, "_alu_abop"}, {alu_a, alu_b, alu_op}, 0);
    chk({tag, "_alu_start"}, alu_start, 0);
    chk({tag, "_busy"}, busy, 0);
    tick();
  endtask

  logic [RW-1:0] r0;
  bit got;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_op = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    reset_chk("rst0");

    // ADD with minimum latency probe
    send(16'd3, 16'd5, 3'b001, 32'h8);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1_start", alu_start, 0);
    @(negedge clk);
    chk("lat_n2_start", alu_start, 1);
    chk("lat_n2_ops", {alu_a, alu_b, alu_op},
        {16'd3, 16'd5, 3'b001});
    tick();
    drain();

    send(16'h0010, 16'h0020, 3'b000, 32'h200);
    drain();

    // Back-to-back stream
    send(16'h00F0, 16'h000F, 3'b100, 32'hFF);
    send(16'h0010, 16'h0003, 3'b010, 32'hD);
    send(16'hF0F0, 16'h0FF0, 3'b101, 32'hF0);
    send(16'hFFFF, 16'h00FF, 3'b110, 32'hFF00);
    send(16'h1234, 16'h0000, 3'b111, 32'hEDCB);
    send(16'hFFFF, 16'hFFFF, 3'b000, 32'hFFFE0001);
    drain();

    // Backpressure: one held in RESP, four fill the FIFO
    rsp_ready = 1'b0;
    send(16'd1, 16'd1, 3'b001, 32'h2);
    send(16'd2, 16'd2, 3'b001, 32'h4);
    send(16'd1, 16'd2, 3'b100, 32'h3);
    send(16'd5, 16'd3, 3'b110, 32'h6);
    send(16'd3, 16'd4, 3'b000, 32'hC);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_full", cmd_ready, 0);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("bp_rsp_valid", got, 1);
    r0 = rsp_result;
    repeat (4) @(negedge clk);
    chk("bp_hold_result", rsp_result, r0);
    chk("bp_first_result", rsp_result, 32'h2);
    chk("bp_hold_op", rsp_op, 3'b001);
    chk("bp_single_start", n_start - n_rsp, 1);
    chk("bp_still_full", cmd_ready, 0);
    chk("bp_busy", busy, 1);
    tick();
    rsp_ready = 1'b1;
    drain();

    // Reset in WAIT of a slow MUL with two queued
    lat_mul = 8;
    send(16'h0010, 16'h0020, 3'b000, 32'h200);
    send(16'd1, 16'd2, 3'b001, 32'h3);
    send(16'd1, 16'd2, 3'b100, 32'h3);
    cmd_valid = 1'b0;
    wait_start();
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1);
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    n_start = 0;
    n_rsp = 0;
    no_rsp = 1'b1;
    reset_chk("rst1");
    repeat (12) tick();
    chk("late_end_idle", busy, 0);
    no_rsp = 1'b0;
    lat_mul = 3;
    send(16'd7, 16'd9, 3'b001, 32'h10);
    drain();

`ifdef ALU_SEQ_TIMEOUT_EN
    alu_en = 1'b0;
    send(16'd1, 16'd1, 3'b001, 32'hFFFFFFFF);
    cmd_valid = 1'b0;
    wait_start();
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        chk("tmo_cycles", k, 17);
      end
    end
    chk("tmo_rsp", got, 1);
    chk("tmo_err", timeout_err, 1);
    tick();
    drain();
    chk("tmo_sticky", timeout_err, 1);
    alu_en = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_start = 0;
    n_rsp = 0;
    @(negedge clk);
    chk("tmo_err_rst", timeout_err, 0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
